count4_arbiter: RTL and testbench

COUNT4_ARBITER -- requirements
Module: count4_arbiter

---
 rtl/count4_arbiter.sv | 152 +++++++++++++++
 tb/tb_count4_arbiter.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/count4_arbiter.sv
// Round-robin arbiter for NREQ requesters that share one 4-bit terminal counter.
// Define COUNT4_ARB_FIXPRIO_EN for fixed lowest-index-wins arbitration.
module count4_arbiter #(
    parameter int NREQ = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req,
    input  logic [4*NREQ-1:0] len,
    input  logic              tick,
    output logic [NREQ-1:0]   gnt,
    output logic [3:0]        q,
    output logic              busy,
    output logic [NREQ-1:0]   done
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t            r_state, w_next_state;
    logic [NREQ-1:0]   r_gnt, w_next_gnt;
    logic [NREQ-1:0]   r_done, w_next_done;
    logic [3:0]        r_q, w_next_q;
    logic [3:0]        r_len, w_next_len;
    logic [PW-1:0]     r_ptr, w_next_ptr;
    logic [PW-1:0]     r_owner, w_next_owner;
    logic              r_busy, w_next_busy;
    logic              w_found;
    logic [PW-1:0]     w_win;
    logic [PW-1:0]     w_idx;

    // Winner selection among the current requests
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = '0;
`ifdef COUNT4_ARB_FIXPRIO_EN
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                w_found = 1'b1;
                w_win   = PW'(i);
            end else begin
                w_found = w_found;
            end
        end
`else
        // Scan starts just after the last grant and wraps around
        for (int k = 1; k <= NREQ; k++) begin
            w_idx = PW'((int'(r_ptr) + k) % NREQ);
            if (!w_found && req[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end else begin
                w_found = w_found;
            end
        end
`endif
    end

    // Next-state and next-output logic
    always_comb begin
        w_next_state = r_state;
        w_next_gnt   = r_gnt;
        w_next_done  = '0;
        w_next_q     = r_q;
        w_next_len   = r_len;
        w_next_ptr   = r_ptr;
        w_next_owner = r_owner;
        case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_next_state = RUN;
                    w_next_gnt   = {{(NREQ-1){1'b0}}, 1'b1} << w_win;
                    w_next_q     = 4'd0;
                    w_next_owner = w_win;
`ifndef COUNT4_ARB_FIXPRIO_EN
                    w_next_ptr   = w_win;
`endif
                    for (int i = 0; i < NREQ; i++) begin
                        if (w_win == PW'(i)) begin
                            w_next_len = len[4*i +: 4];
                        end else begin
                            w_next_len = w_next_len;
                        end
                    end
                end else begin
                    w_next_state = IDLE;
                end
            end
            RUN: begin
                // Cancel wins over a completion in the same cycle
                if (!req[r_owner]) begin
                    w_next_state = RELEASE;
                    w_next_gnt   = '0;
                end else if (tick) begin
                    if (r_q == r_len) begin
                        w_next_state = RELEASE;
                        w_next_gnt   = '0;
                        w_next_done  = r_gnt;
                    end else begin
                        w_next_q = r_q + 4'd1;
                    end
                end else begin
                    w_next_state = RUN;
                end
            end
            RELEASE: begin
                w_next_state = IDLE;
                w_next_gnt   = '0;
            end
            default: begin
                w_next_state = IDLE;
                w_next_gnt   = '0;
            end
        endcase
        w_next_busy = (w_next_state != IDLE);
    end

    // State and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_gnt   <= '0;
            r_done  <= '0;
            r_q     <= 4'd0;
            r_len   <= 4'd0;
            r_ptr   <= PW'(NREQ - 1);
            r_owner <= '0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_gnt   <= w_next_gnt;
            r_done  <= w_next_done;
            r_q     <= w_next_q;
            r_len   <= w_next_len;
            r_ptr   <= w_next_ptr;
            r_owner <= w_next_owner;
            r_busy  <= w_next_busy;
        end
    end

    assign gnt  = r_gnt;
    assign q    = r_q;
    assign busy = r_busy;
    assign done = r_done;

endmodule

// File: tb/tb_count4_arbiter.sv
// Scoreboard bench for count4_arbiter: each step pairs stimulus with the expected
// post-edge gnt/q/busy/done values, compared one cycle at a time.
module tb_count4_arbiter;

    logic        clk;
    logic        reset;
    logic [3:0]  req;
    logic [15:0] len;
    logic        tick;
    logic [3:0]  gnt;
    logic [3:0]  q;
    logic        busy;
    logic [3:0]  done;

    int checks;
    int failures;

    typedef struct {
        logic [3:0]  req;
        logic [15:0] len;
        logic        tick;
        logic [3:0]  gnt;
        logic [3:0]  q;
        logic        busy;
        logic [3:0]  done;
    } step_t;

    step_t sb[$];
    step_t s;

    count4_arbiter #(.NREQ(4)) dut (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .len   (len),
        .tick  (tick),
        .gnt   (gnt),
        .q     (q),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic push(input logic [3:0] r, input logic [15:0] l, input logic t,
                        input logic [3:0] g, input logic [3:0] qq, input logic b,
                        input logic [3:0] d);
        step_t e;
        e.req = r; e.len = l; e.tick = t; e.gnt = g; e.q = qq; e.busy = b; e.done = d;
        sb.push_back(e);
    endtask

    task automatic test_reset();
        reset = 1'b1; req = 4'd0; len = 16'd0; tick = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({gnt, q, busy, done} !== 13'd0) begin
            failures++;
            $display("FAIL reset_state: got gnt=%b q=%0d busy=%b done=%b, expected all zero", gnt, q, busy, done);
        end
        @(negedge clk); reset = 1'b0;
    endtask

    task automatic test_single();
        int n = 0;
        push(4'b0001, 16'h0003, 1'b1, 4'b0001, 4'd0, 1'b1, 4'b0000);
        for (int k = 1; k <= 3; k++) push(4'b0001, 16'h0003, 1'b1, 4'b0001, 4'(k), 1'b1, 4'b0000);
        push(4'b0001, 16'h0003, 1'b1, 4'b0000, 4'd3, 1'b1, 4'b0001);
        push(4'b0000, 16'h0003, 1'b1, 4'b0000, 4'd3, 1'b0, 4'b0000);
        push(4'b0000, 16'h0003, 1'b1, 4'b0000, 4'd3, 1'b0, 4'b0000);
        while (sb.size() != 0) begin
            s = sb.pop_front();
            @(negedge clk); req = s.req; len = s.len; tick = s.tick;
            @(posedge clk); #1;
            checks++;
            if ({gnt, q, busy, done} !== {s.gnt, s.q, s.busy, s.done}) begin
                failures++;
                $display("FAIL single cyc%0d: got gnt=%b q=%0d busy=%b done=%b, expected gnt=%b q=%0d busy=%b done=%b",
                         n, gnt, q, busy, done, s.gnt, s.q, s.busy, s.done);
            end
            n++;
        end
    endtask

    task automatic test_round_robin();
        int n = 0;
        int w;
        @(negedge clk); reset = 1'b1; req = 4'd0;
        @(negedge clk); reset = 1'b0;
        for (int g = 0; g < 5; g++) begin
`ifdef COUNT4_ARB_FIXPRIO_EN
            w = 0;
`else
            w = g % 4;
`endif
            push(4'b1111, 16'h0000, 1'b1, 4'(1 << w), 4'd0, 1'b1, 4'b0000);
            push(4'b1111, 16'h0000, 1'b1, 4'b0000, 4'd0, 1'b1, 4'(1 << w));
            push(4'b1111, 16'h0000, 1'b1, 4'b0000, 4'd0, 1'b0, 4'b0000);
        end
        while (sb.size() != 0) begin
            s = sb.pop_front();
            @(negedge clk); req = s.req; len = s.len; tick = s.tick;
            @(posedge clk); #1;
            checks++;
            if ({gnt, q, busy, done} !== {s.gnt, s.q, s.busy, s.done}) begin
                failures++;
                $display("FAIL round_robin cyc%0d: got gnt=%b q=%0d busy=%b done=%b, expected gnt=%b q=%0d busy=%b done=%b",
                         n, gnt, q, busy, done, s.gnt, s.q, s.busy, s.done);
            end
            n++;
        end
    endtask

    task automatic test_tick_gating();
        int n = 0;
        logic tp [4];
        logic [3:0] eq;
        tp[0] = 1'b1; tp[1] = 1'b0; tp[2] = 1'b0; tp[3] = 1'b1;
        eq = 4'd0;
        push(4'b0100, 16'h0200, 1'b1, 4'b0100, 4'd0, 1'b1, 4'b0000);
        for (int k = 0; k < 4; k++) begin
            if (tp[k]) eq = eq + 4'd1;
            push(4'b0100, 16'h0200, tp[k], 4'b0100, eq, 1'b1, 4'b0000);
        end
        push(4'b0100, 16'h0200, 1'b1, 4'b0000, 4'd2, 1'b1, 4'b0100);
        push(4'b0000, 16'h0200, 1'b0, 4'b0000, 4'd2, 1'b0, 4'b0000);
        while (sb.size() != 0) begin
            s = sb.pop_front();
            @(negedge clk); req = s.req; len = s.len; tick = s.tick;
            @(posedge clk); #1;
            checks++;
            if ({gnt, q, busy, done} !== {s.gnt, s.q, s.busy, s.done}) begin
                failures++;
                $display("FAIL tick_gating cyc%0d: got gnt=%b q=%0d busy=%b done=%b, expected gnt=%b q=%0d busy=%b done=%b",
                         n, gnt, q, busy, done, s.gnt, s.q, s.busy, s.done);
            end
            n++;
        end
    endtask

    task automatic test_cancel();
        int n = 0;
        push(4'b0100, 16'h0900, 1'b1, 4'b0100, 4'd0, 1'b1, 4'b0000);
        // Owner len shrinks and a non-owner joins mid-run; neither may matter
        for (int k = 1; k <= 4; k++)
            push(4'b0101, 16'h0100 | 16'(k), 1'b1, 4'b0100, 4'(k), 1'b1, 4'b0000);
        push(4'b0001, 16'h0100, 1'b1, 4'b0000, 4'd4, 1'b1, 4'b0000);
        push(4'b0000, 16'h0100, 1'b1, 4'b0000, 4'd4, 1'b0, 4'b0000);
        while (sb.size() != 0) begin
            s = sb.pop_front();
            @(negedge clk); req = s.req; len = s.len; tick = s.tick;
            @(posedge clk); #1;
            checks++;
            if ({gnt, q, busy, done} !== {s.gnt, s.q, s.busy, s.done}) begin
                failures++;
                $display("FAIL cancel cyc%0d: got gnt=%b q=%0d busy=%b done=%b, expected gnt=%b q=%0d busy=%b done=%b",
                         n, gnt, q, busy, done, s.gnt, s.q, s.busy, s.done);
            end
            n++;
        end
    endtask

    task automatic test_reset_mid_run();
        int n = 0;
        push(4'b0001, 16'h000A, 1'b1, 4'b0001, 4'd0, 1'b1, 4'b0000);
        for (int k = 1; k <= 5; k++) push(4'b0001, 16'h000A, 1'b1, 4'b0001, 4'(k), 1'b1, 4'b0000);
        while (sb.size() != 0) begin
            s = sb.pop_front();
            @(negedge clk); req = s.req; len = s.len; tick = s.tick;
            @(posedge clk); #1;
            checks++;
            if ({gnt, q, busy, done} !== {s.gnt, s.q, s.busy, s.done}) begin
                failures++;
                $display("FAIL reset_mid pre cyc%0d: got gnt=%b q=%0d busy=%b done=%b, expected gnt=%b q=%0d busy=%b done=%b",
                         n, gnt, q, busy, done, s.gnt, s.q, s.busy, s.done);
            end
            n++;
        end
        @(negedge clk); reset = 1'b1;
        #1;
        checks++;
        if ({gnt, q, busy, done} !== 13'd0) begin
            failures++;
            $display("FAIL reset_mid async: got gnt=%b q=%0d busy=%b done=%b, expected all zero", gnt, q, busy, done);
        end
        @(posedge clk); #1;
        checks++;
        if ({gnt, q, busy, done} !== 13'd0) begin
            failures++;
            $display("FAIL reset_mid held: got gnt=%b q=%0d busy=%b done=%b, expected all zero", gnt, q, busy, done);
        end
        @(negedge clk); reset = 1'b0; req = 4'b0010; len = 16'h0010; tick = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({gnt, q, busy, done} !== {4'b0010, 4'd0, 1'b1, 4'b0000}) begin
            failures++;
            $display("FAIL reset_mid first_grant: got gnt=%b q=%0d busy=%b done=%b, expected gnt=0010 q=0 busy=1 done=0000",
                     gnt, q, busy, done);
        end
        push(4'b0010, 16'h0010, 1'b1, 4'b0010, 4'd1, 1'b1, 4'b0000);
        push(4'b0010, 16'h0010, 1'b1, 4'b0000, 4'd1, 1'b1, 4'b0010);
        push(4'b0000, 16'h0010, 1'b1, 4'b0000, 4'd1, 1'b0, 4'b0000);
        n = 0;
        while (sb.size() != 0) begin
            s = sb.pop_front();
            @(negedge clk); req = s.req; len = s.len; tick = s.tick;
            @(posedge clk); #1;
            checks++;
            if ({gnt, q, busy, done} !== {s.gnt, s.q, s.busy, s.done}) begin
                failures++;
                $display("FAIL reset_mid post cyc%0d: got gnt=%b q=%0d busy=%b done=%b, expected gnt=%b q=%0d busy=%b done=%b",
                         n, gnt, q, busy, done, s.gnt, s.q, s.busy, s.done);
            end
            n++;
        end
    endtask

    task automatic test_boundary();
        int n = 0;
        push(4'b1000, 16'hF000, 1'b1, 4'b1000, 4'd0, 1'b1, 4'b0000);
        for (int k = 1; k <= 15; k++) push(4'b1000, 16'hF000, 1'b1, 4'b1000, 4'(k), 1'b1, 4'b0000);
        push(4'b1000, 16'hF000, 1'b1, 4'b0000, 4'd15, 1'b1, 4'b1000);
        push(4'b0000, 16'hF000, 1'b1, 4'b0000, 4'd15, 1'b0, 4'b0000);
        while (sb.size() != 0) begin
            s = sb.pop_front();
            @(negedge clk); req = s.req; len = s.len; tick = s.tick;
            @(posedge clk); #1;
            checks++;
            if ({gnt, q, busy, done} !== {s.gnt, s.q, s.busy, s.done}) begin
                failures++;
                $display("FAIL boundary cyc%0d: got gnt=%b q=%0d busy=%b done=%b, expected gnt=%b q=%0d busy=%b done=%b",
                         n, gnt, q, busy, done, s.gnt, s.q, s.busy, s.done);
            end
            n++;
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_single();
        test_round_robin();
        test_tick_gating();
        test_cancel();
        test_reset_mid_run();
        test_boundary();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
